// File: rtl/sync_fifo_pkg.sv
// Shared types for the synchronous FIFO: read-port mode selection.
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

endpackage

// File: rtl/sync_fifo_ptr.sv
// Modulo-DEPTH wrapping pointer with increment enable and synchronous clear.
module sync_fifo_ptr #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags, sticky error flags and
// selectable registered / first-word-fall-through read port.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter fifo_mode_e  FIFO_MODE     = FIFO_STD,
  parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int unsigned AEMPTY_THRESH = 1,
  localparam int unsigned CW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_rst_n,
  input  logic                  fifo_flush,
  input  logic                  fifo_wen,
  input  logic [FIFO_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_ren,
  output logic [FIFO_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rvalid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_afull,
  output logic                  fifo_aempty,
  output logic [CW-1:0]         fifo_count,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow,
  input  logic                  fifo_err_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  if (FIFO_DEPTH < 2) begin : g_chk_depth
    $error("sync_fifo: FIFO_DEPTH must be at least 2");
  end
  if (AFULL_THRESH > FIFO_DEPTH) begin : g_chk_afull
    $error("sync_fifo: AFULL_THRESH must not exceed FIFO_DEPTH");
  end
  if (AEMPTY_THRESH >= FIFO_DEPTH) begin : g_chk_aempty
    $error("sync_fifo: AEMPTY_THRESH must be below FIFO_DEPTH");
  end

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;

  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic rd_acc, wr_acc, rd_en, wr_en, ovf_ev, udf_ev;

  assign rd_acc = fifo_ren && !empty_q;
  assign wr_acc = fifo_wen && (!full_q || rd_acc);
  // Flush outranks traffic: accepted requests are suppressed, not queued.
  assign rd_en  = rd_acc && !fifo_flush;
  assign wr_en  = wr_acc && !fifo_flush;
  assign ovf_ev = fifo_wen && full_q && !rd_acc && !fifo_flush;
  assign udf_ev = fifo_ren && empty_q && !fifo_flush;

  sync_fifo_ptr #(.DEPTH(FIFO_DEPTH), .PW(AW)) u_rd_ptr (
    .clk  (fifo_clk),
    .rst_n(fifo_rst_n),
    .clr  (fifo_flush),
    .inc  (rd_en),
    .ptr  (rd_ptr)
  );

  sync_fifo_ptr #(.DEPTH(FIFO_DEPTH), .PW(AW)) u_wr_ptr (
    .clk  (fifo_clk),
    .rst_n(fifo_rst_n),
    .clr  (fifo_flush),
    .inc  (wr_en),
    .ptr  (wr_ptr)
  );

  // Flags come from the next count so they line up with fifo_count.
  always_comb begin
    count_d = count_q;
    if (fifo_flush) begin
      count_d = '0;
    end else if (wr_en && !rd_en) begin
      count_d = count_q + CW'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CW'(1);
    end
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
    ovf_d    = ovf_ev || (ovf_q && !fifo_err_clr);
    udf_d    = udf_ev || (udf_q && !fifo_err_clr);
  end

  always_ff @(posedge fifo_clk) begin
    if (!fifo_rst_n) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= (AFULL_THRESH == 0);
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // NOTE: the storage array has no reset; pointers and count define what is
  // visible, so stale entries can never reach the read port.
  always_ff @(posedge fifo_clk) begin
    if (fifo_rst_n && wr_en) begin
      mem_q[wr_ptr] <= fifo_wdata;
    end
  end

  if (FIFO_MODE == FIFO_STD) begin : g_std
    logic [FIFO_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      if (rd_en) begin
        rdata_d  = mem_q[rd_ptr];
        rvalid_d = 1'b1;
      end
    end

    always_ff @(posedge fifo_clk) begin
      if (!fifo_rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign fifo_rdata  = rdata_q;
    assign fifo_rvalid = rvalid_q;
  end else begin : g_fwft
    // Head is shown directly; an empty FIFO presents zero rather than stale data.
    assign fifo_rdata  = empty_q ? '0 : mem_q[rd_ptr];
    assign fifo_rvalid = !empty_q;
  end

  assign fifo_full      = full_q;
  assign fifo_empty     = empty_q;
  assign fifo_afull     = afull_q;
  assign fifo_aempty    = aempty_q;
  assign fifo_count     = count_q;
  assign fifo_overflow  = ovf_q;
  assign fifo_underflow = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: a registered-read and an FWFT instance (depth 5) share
// stimulus and are compared each cycle against a queue-based reference model.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DEPTH = 5;
  localparam int W     = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0, flush = 1'b0, wen = 1'b0, ren = 1'b0, err_clr = 1'b0;
  logic [W-1:0] wdata = '0;

  logic [W-1:0]  s_rdata, f_rdata;
  logic          s_rvalid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
  logic          f_rvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [CW-1:0] s_count, f_count;

  sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .FIFO_MODE(FIFO_STD),
              .AFULL_THRESH(4), .AEMPTY_THRESH(1)) u_std (
    .fifo_clk(clk), .fifo_rst_n(rst_n), .fifo_flush(flush),
    .fifo_wen(wen), .fifo_wdata(wdata), .fifo_ren(ren),
    .fifo_rdata(s_rdata), .fifo_rvalid(s_rvalid), .fifo_full(s_full),
    .fifo_empty(s_empty), .fifo_afull(s_afull), .fifo_aempty(s_aempty),
    .fifo_count(s_count), .fifo_overflow(s_ovf), .fifo_underflow(s_udf),
    .fifo_err_clr(err_clr)
  );

  sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .FIFO_MODE(FIFO_FWFT),
              .AFULL_THRESH(4), .AEMPTY_THRESH(1)) u_fwft (
    .fifo_clk(clk), .fifo_rst_n(rst_n), .fifo_flush(flush),
    .fifo_wen(wen), .fifo_wdata(wdata), .fifo_ren(ren),
    .fifo_rdata(f_rdata), .fifo_rvalid(f_rvalid), .fifo_full(f_full),
    .fifo_empty(f_empty), .fifo_afull(f_afull), .fifo_aempty(f_aempty),
    .fifo_count(f_count), .fifo_overflow(f_ovf), .fifo_underflow(f_udf),
    .fifo_err_clr(err_clr)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, registered-read output, sticky flags.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_rdata  = '0;
  logic         m_rvalid = 1'b0;
  logic         m_ovf    = 1'b0;
  logic         m_udf    = 1'b0;

  task automatic model_step();
    int n;
    bit rd, wr, ovf_ev, udf_ev;
    if (!rst_n) begin
      mq.delete();
      m_rdata  = '0;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
      return;
    end
    n      = mq.size();
    ovf_ev = 1'b0;
    udf_ev = 1'b0;
    if (flush) begin
      mq.delete();
      m_rvalid = 1'b0;
    end else begin
      rd     = ren && (n > 0);
      wr     = wen && ((n < DEPTH) || rd);
      ovf_ev = wen && !wr;
      udf_ev = ren && (n == 0);
      m_rvalid = rd;
      if (rd) m_rdata = mq.pop_front();
      if (wr) mq.push_back(wdata);
    end
    m_ovf = ovf_ev || (m_ovf && !err_clr);
    m_udf = udf_ev || (m_udf && !err_clr);
  endtask

  task automatic compare_all();
    int n;
    logic [W-1:0] head;
    n    = mq.size();
    head = '0;
    if (n > 0) head = mq[0];
    check("std count",  32'(s_count), n);
    check("std full",   s_full,   n == DEPTH);
    check("std empty",  s_empty,  n == 0);
    check("std afull",  s_afull,  n >= 4);
    check("std aempty", s_aempty, n <= 1);
    check("std rdata",  s_rdata,  m_rdata);
    check("std rvalid", s_rvalid, m_rvalid);
    check("std ovf",    s_ovf,    m_ovf);
    check("std udf",    s_udf,    m_udf);
    check("fwft count", 32'(f_count), n);
    check("fwft full",  f_full,   n == DEPTH);
    check("fwft empty", f_empty,  n == 0);
    check("fwft rdata", f_rdata,  head);
    check("fwft rvalid", f_rvalid, n > 0);
    check("fwft ovf",   f_ovf,    m_ovf);
    check("fwft udf",   f_udf,    m_udf);
  endtask

  task automatic drive(input logic r, input logic fl, input logic we, input logic [W-1:0] wd,
                       input logic re, input logic ec);
    @(negedge clk);
    rst_n   = r;
    flush   = fl;
    wen     = we;
    wdata   = wd;
    ren     = re;
    err_clr = ec;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic cycle(input logic r, input logic fl, input logic we, input logic [W-1:0] wd,
                       input logic re, input logic ec);
    drive(r, fl, we, wd, re, ec);
    tick();
  endtask

  typedef struct {
    string        name;
    logic         wen;
    logic [W-1:0] wdata;
    logic         ren;
    logic         err_clr;
    int           count;
    logic         full, empty, ovf, udf, rvalid;
    logic [W-1:0] rdata;
  } vec_t;

  vec_t vecs[14];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [W-1:0] exp26 [5];
    logic [5:0]   ae_exp;
    logic [5:0]   af_exp;
    int           wprob;

    //                name     wen wdata  ren clr cnt full empty ovf udf rv  rdata
    vecs[0]  = '{"w11",    1, 8'h11, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00};
    vecs[1]  = '{"w12",    1, 8'h12, 0, 0, 2, 0, 0, 0, 0, 0, 8'h00};
    vecs[2]  = '{"w13",    1, 8'h13, 0, 0, 3, 0, 0, 0, 0, 0, 8'h00};
    vecs[3]  = '{"w14",    1, 8'h14, 0, 0, 4, 0, 0, 0, 0, 0, 8'h00};
    vecs[4]  = '{"w15",    1, 8'h15, 0, 0, 5, 1, 0, 0, 0, 0, 8'h00};
    vecs[5]  = '{"w16_ovf", 1, 8'h16, 0, 0, 5, 1, 0, 1, 0, 0, 8'h00};
    vecs[6]  = '{"r11",    0, 8'h00, 1, 0, 4, 0, 0, 1, 0, 1, 8'h11};
    vecs[7]  = '{"r12",    0, 8'h00, 1, 0, 3, 0, 0, 1, 0, 1, 8'h12};
    vecs[8]  = '{"r13",    0, 8'h00, 1, 0, 2, 0, 0, 1, 0, 1, 8'h13};
    vecs[9]  = '{"r14",    0, 8'h00, 1, 0, 1, 0, 0, 1, 0, 1, 8'h14};
    vecs[10] = '{"r15",    0, 8'h00, 1, 0, 0, 0, 1, 1, 0, 1, 8'h15};
    vecs[11] = '{"idle",   0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0, 8'h15};
    vecs[12] = '{"r_udf",  0, 8'h00, 1, 0, 0, 0, 1, 1, 1, 0, 8'h15};
    vecs[13] = '{"errclr", 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 0, 8'h15};

    // Reset state
    cycle(0, 0, 0, 8'h00, 0, 0);
    cycle(0, 0, 0, 8'h00, 0, 0);
    check("rst count",  32'(s_count), 0);
    check("rst empty",  s_empty,  1'b1);
    check("rst aempty", s_aempty, 1'b1);
    check("rst full",   s_full,   1'b0);
    check("rst afull",  s_afull,  1'b0);
    check("rst rdata",  s_rdata,  8'h00);
    check("rst rvalid", s_rvalid, 1'b0);
    check("rst fwft rvalid", f_rvalid, 1'b0);

    // Fill / overflow / drain / underflow / error clear
    for (int i = 0; i < 14; i++) begin
      cycle(1, 0, vecs[i].wen, vecs[i].wdata, vecs[i].ren, vecs[i].err_clr);
      check({vecs[i].name, " count"},  32'(s_count), vecs[i].count);
      check({vecs[i].name, " full"},   s_full,   vecs[i].full);
      check({vecs[i].name, " empty"},  s_empty,  vecs[i].empty);
      check({vecs[i].name, " ovf"},    s_ovf,    vecs[i].ovf);
      check({vecs[i].name, " udf"},    s_udf,    vecs[i].udf);
      check({vecs[i].name, " rvalid"}, s_rvalid, vecs[i].rvalid);
      check({vecs[i].name, " rdata"},  s_rdata,  vecs[i].rdata);
    end

    // Write accepted while full thanks to a same-cycle read; wraps index 4->0
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 8'h21 + 8'(i), 0, 0);
    check("full26 full", s_full, 1'b1);
    cycle(1, 0, 1, 8'hAA, 1, 0);
    check("wr+rd full count", 32'(s_count), 5);
    check("wr+rd full rdata", s_rdata, 8'h21);
    check("wr+rd full rvalid", s_rvalid, 1'b1);
    check("wr+rd full no ovf", s_ovf, 1'b0);
    exp26 = '{8'h22, 8'h23, 8'h24, 8'h25, 8'hAA};
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 8'h00, 1, 0);
      check("wrap read rdata", s_rdata, exp26[i]);
    end
    check("wrap drained empty", s_empty, 1'b1);

    // Almost-full / almost-empty thresholds across counts 0..5
    ae_exp = 6'b000011;
    af_exp = 6'b110000;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i > 0) cycle(1, 0, 1, 8'h40 + 8'(i), 0, 0);
      check("thresh aempty", s_aempty, ae_exp[i]);
      check("thresh afull",  s_afull,  af_exp[i]);
      check("thresh fwft afull", f_afull, af_exp[i]);
      check("thresh fwft aempty", f_aempty, ae_exp[i]);
    end
    cycle(1, 1, 0, 8'h00, 0, 0);

    // FWFT: no bypass on write into empty, then visible next cycle
    drive(1, 0, 1, 8'h5A, 0, 0);
    #1;
    check("fwft no bypass rvalid", f_rvalid, 1'b0);
    check("fwft no bypass rdata", f_rdata, 8'h00);
    tick();
    check("fwft head rdata", f_rdata, 8'h5A);
    check("fwft head rvalid", f_rvalid, 1'b1);
    cycle(1, 0, 0, 8'h00, 1, 0);
    check("fwft pop empty", f_empty, 1'b1);
    check("fwft pop rvalid", f_rvalid, 1'b0);
    check("std pop rdata", s_rdata, 8'h5A);

    // Flush with a same-cycle write
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 8'h31 + 8'(i), 0, 0);
    check("pre-flush count", 32'(s_count), 3);
    cycle(1, 1, 1, 8'h77, 0, 0);
    check("flush count", 32'(s_count), 0);
    check("flush empty", s_empty, 1'b1);
    cycle(1, 0, 0, 8'h00, 0, 0);
    check("flush write ignored", 32'(f_count), 0);

    // Reset mid-burst with overflow set and read data live
    for (int i = 0; i < 6; i++) cycle(1, 0, 1, 8'h90 + 8'(i), 0, 0);
    cycle(1, 0, 1, 8'h99, 1, 0);
    check("pre-rst ovf", s_ovf, 1'b1);
    check("pre-rst rvalid", s_rvalid, 1'b1);
    cycle(0, 0, 1, 8'h55, 1, 0);
    check("midrst count",  32'(s_count), 0);
    check("midrst empty",  s_empty,  1'b1);
    check("midrst full",   s_full,   1'b0);
    check("midrst afull",  s_afull,  1'b0);
    check("midrst aempty", s_aempty, 1'b1);
    check("midrst rdata",  s_rdata,  8'h00);
    check("midrst rvalid", s_rvalid, 1'b0);
    check("midrst ovf",    s_ovf,    1'b0);
    check("midrst udf",    s_udf,    1'b0);
    check("midrst fwft rdata", f_rdata, 8'h00);

    // Randomized traffic against the model, with phase-varying write bias
    wprob = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) wprob = (i / 200 % 3 == 0) ? 30 : ((i / 200 % 3 == 1) ? 50 : 80);
      cycle($urandom_range(0, 299) != 0,
            $urandom_range(0, 31) == 0,
            $urandom_range(0, 99) < wprob,
            8'($urandom),
            $urandom_range(0, 99) < (110 - wprob),
            $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8: data width in bits (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: entry count, any integer >=2 (power of two not required).
REQ-003 SHALL have parameter FIFO_MODE, default FIFO_STD: read mode, FIFO_STD (registered read) or FIFO_FWFT (first-word-fall-through).
REQ-004 SHALL have parameter AFULL_THRESH, default FIFO_DEPTH-1: almost-full level.
REQ-005 SHALL have parameter AEMPTY_THRESH, default 1: almost-empty level.
REQ-006 Port list, in order (CW = $clog2(FIFO_DEPTH+1)):
- fifo_clk  input  1  single clock; all logic on rising edge.
- fifo_rst_n  input  1  reset, synchronous, active-low.
- fifo_flush  input  1  synchronous clear of contents.
- fifo_wen  input  1  write request.
- fifo_wdata  input  FIFO_WIDTH  write data.
- fifo_ren  input  1  read request.
- fifo_rdata  output  FIFO_WIDTH  read data.
- fifo_rvalid  output  1  fifo_rdata valid.
- fifo_full  output  1  count == FIFO_DEPTH.
- fifo_empty  output  1  count == 0.
- fifo_afull  output  1  count >= AFULL_THRESH.
- fifo_aempty  output  1  count <= AEMPTY_THRESH.
- fifo_count  output  CW  current occupancy.
- fifo_overflow  output  1  sticky: write dropped.
- fifo_underflow  output  1  sticky: read on empty.
- fifo_err_clr  input  1  clears sticky flags.

Function
REQ-007 Read accepted (rd_acc) SHALL be fifo_ren && !fifo_empty.
REQ-008 Write accepted (wr_acc) SHALL be fifo_wen && (!fifo_full || rd_acc); a write while full with a same-cycle accepted read SHALL be accepted.
REQ-009 A write on empty SHALL NOT bypass to the read port; data becomes readable the cycle after wr_acc.
REQ-010 Write/read pointers SHALL range 0..FIFO_DEPTH-1 and wrap from FIFO_DEPTH-1 to 0.
REQ-011 fifo_count SHALL update next cycle by +1 (wr_acc only), -1 (rd_acc only), 0 (both or neither); it never exceeds FIFO_DEPTH or goes below 0.
REQ-012 Status flags SHALL be registered, derived from next-state count, and valid in the same cycle as fifo_count.
REQ-013 FIFO_STD: on rd_acc, fifo_rdata SHALL load the head entry at the next edge and fifo_rvalid SHALL pulse high for exactly that one cycle; fifo_rdata holds otherwise.
REQ-014 FIFO_FWFT: fifo_rdata SHALL continuously present the head entry, fifo_rvalid SHALL equal !fifo_empty, and rd_acc pops the head.
REQ-015 fifo_wen && fifo_full && !rd_acc SHALL drop the write and set fifo_overflow next cycle.
REQ-016 fifo_ren && fifo_empty SHALL leave state unchanged and set fifo_underflow next cycle.
REQ-017 fifo_err_clr SHALL clear both sticky flags next cycle; a same-cycle new error SHALL win (flag stays set).
REQ-018 fifo_flush SHALL zero pointers and count and deassert fifo_rvalid next cycle, ignoring same-cycle wen/ren; sticky flags and memory contents are unaffected.
REQ-019 Priority SHALL be reset > flush > read/write.

Reset
REQ-020 On fifo_rst_n low at a clock edge: pointers, count, fifo_rdata, fifo_rvalid, fifo_overflow, fifo_underflow SHALL be 0; fifo_empty = 1, fifo_aempty = 1, fifo_full = 0, fifo_afull = (AFULL_THRESH == 0).
REQ-021 Memory array SHALL NOT be reset; reset mid-operation SHALL discard all contents.

Structure
REQ-022 Package sync_fifo_pkg SHALL hold the fifo_mode_e enum (FIFO_STD, FIFO_FWFT).
REQ-023 Sub-module sync_fifo_ptr SHALL implement the modulo-FIFO_DEPTH wrapping pointer with increment enable and clear; it is instantiated for the read and write pointers.
REQ-024 Elaboration SHALL fail on FIFO_DEPTH < 2, AFULL_THRESH > FIFO_DEPTH, or AEMPTY_THRESH >= FIFO_DEPTH.

Verification
REQ-025 DEPTH=5, STD: write 0x11..0x15 -> full=1 and count=5 after the 5th write; sixth write 0x16 -> dropped, overflow=1; read 5 -> 0x11..0x15, each with a 1-cycle rvalid.
REQ-026 DEPTH=5, fill to full, then wen+ren in the same cycle with 0xAA -> count stays 5, read returns old head; 0xAA appears as the 5th subsequent read (checks wrap across index 4->0).
REQ-027 Empty FIFO, ren=1 -> underflow=1, count=0, rvalid=0; err_clr -> underflow=0 next cycle.
REQ-028 FWFT, write 0x5A into empty -> next cycle rdata=0x5A, rvalid=1; ren -> empty=1, rvalid=0 next cycle.
REQ-029 AFULL_THRESH=4, AEMPTY_THRESH=1: counts 0..5 -> aempty high at 0 and 1, afull high at 4 and 5.
REQ-030 With count=3, assert flush together with wen -> count=0, empty=1, write ignored; assert rst_n low mid-burst -> all outputs at reset values next edge.
